// File: rtl/audioadc_cic_decim_pkg.sv
// -----------------------------------------------------------------------------
// audioadc_cic_decim_pkg
//   Shared constants and helpers for the receive-side CIC decimator.
//   The OSR code encoding and decimation-counter reload values are the same
//   ones used by the DAC modulator, so a loopback needs no translation.
//
//   Contents:
//     CIC_ORDER, ACC_W, SAMPLE_W, SETTLE_CNT   filter geometry
//     osr_e                                    OSR code (0=32 .. 3=256)
//     CTR_OSR*                                 dec_ctr reload values (R-1)
//     OFFSET_ZERO                              offset-binary zero
//     osr_reload(), osr_shift()                per-OSR reload / output shift
// -----------------------------------------------------------------------------
package audioadc_cic_decim_pkg;

    localparam int CIC_ORDER  = 3;
    // 3 stages * log2(256) bits of growth + 1 input bit + 1 sign bit.
    localparam int ACC_W      = 26;
    localparam int SAMPLE_W   = 16;
    localparam int SETTLE_CNT = 3;
    localparam int SETTLE_W   = 2;
    localparam int CTR_W      = 8;

    typedef enum logic [1:0] {
        OSR32  = 2'd0,
        OSR64  = 2'd1,
        OSR128 = 2'd2,
        OSR256 = 2'd3
    } osr_e;

    localparam logic [CTR_W-1:0] CTR_OSR32  = 8'd31;
    localparam logic [CTR_W-1:0] CTR_OSR64  = 8'd63;
    localparam logic [CTR_W-1:0] CTR_OSR128 = 8'd127;
    localparam logic [CTR_W-1:0] CTR_OSR256 = 8'd255;

    localparam logic [SAMPLE_W-1:0] OFFSET_ZERO   = 16'h8000;
    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CNT);

    // Frame length minus one for a given OSR code.
    function automatic logic [CTR_W-1:0] osr_reload(input osr_e osr);
        logic [CTR_W-1:0] r;
        case (osr)
            OSR32:   r = CTR_OSR32;
            OSR64:   r = CTR_OSR64;
            OSR128:  r = CTR_OSR128;
            default: r = CTR_OSR256;
        endcase
        return r;
    endfunction

    // Comb output spans +/-R^3 = +/-2^(3k); shifting by 3k-15 maps it onto
    // a 16-bit signed range (only +R^3 then needs saturation).
    function automatic logic [3:0] osr_shift(input osr_e osr);
        logic [3:0] s;
        case (osr)
            OSR32:   s = 4'd0;
            OSR64:   s = 4'd3;
            OSR128:  s = 4'd6;
            default: s = 4'd9;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/audioadc_cic_comb.sv
// -----------------------------------------------------------------------------
// audioadc_cic_comb
//   Comb half of the 3rd-order CIC decimator plus output formatting:
//   three differentiators evaluated once per frame, arithmetic scaling shift,
//   saturation to 16-bit signed, and conversion to offset-binary.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     clear        synchronous clear of the comb delays (sample holds)
//     strobe       decimation boundary: evaluate combs, register sample
//     osr          OSR of the frame that just ended (selects the shift)
//     integ        last integrator output (modulo 2^ACC_W)
//     sample       registered offset-binary sample
// -----------------------------------------------------------------------------
module audioadc_cic_comb
    import audioadc_cic_decim_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                strobe,
    input  osr_e                osr,
    input  logic [ACC_W-1:0]    integ,
    output logic [SAMPLE_W-1:0] sample
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    logic [ACC_W-1:0]        d1, d2, d3;
    logic [ACC_W-1:0]        c1, c2, c3;
    logic signed [ACC_W-1:0] scaled;
    logic [SAMPLE_W-1:0]     sat;
    logic [SAMPLE_W-1:0]     uint_val;

    // Differences are taken modulo 2^ACC_W; integrator wrap-around cancels
    // here because the true comb output always fits in ACC_W bits.
    always_comb begin
        c1     = integ - d1;
        c2     = c1 - d2;
        c3     = c2 - d3;
        scaled = $signed(c3) >>> osr_shift(osr);
        if (scaled > SAT_MAX) begin
            sat = 16'h7FFF;
        end else if (scaled < SAT_MIN) begin
            sat = 16'h8000;
        end else begin
            sat = scaled[SAMPLE_W-1:0];
        end
        uint_val = {~sat[SAMPLE_W-1], sat[SAMPLE_W-2:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            sample <= OFFSET_ZERO;
        end else if (clear) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (strobe) begin
            d1     <= integ;
            d2     <= c1;
            d3     <= c2;
            sample <= uint_val;
        end
    end

endmodule

// File: rtl/audioadc_cic_decim.sv
// -----------------------------------------------------------------------------
// audioadc_cic_decim
//   Receive side of the audio delta-sigma path: 1-bit bitstream in,
//   3rd-order CIC decimation, 16-bit offset-binary samples out to the RX FIFO.
//
//   Ports:
//     clk_i        modulator-rate clock, one bitstream bit per cycle
//     rst_n_i      asynchronous active-low reset
//     ds_i         bitstream bit (1 -> +1, 0 -> -1)
//     enable_i     0 holds the filter cleared (sample_o / overrun_o hold)
//     osr_i        OSR code 0=32 1=64 2=128 3=256, latched at frame boundaries
//     fifo_full_i  RX FIFO full
//     sample_o     last decimated sample, offset-binary
//     sample_wr_o  one-cycle write strobe to the FIFO
//     overrun_o    sticky: a sample was dropped because the FIFO was full
//     ovr_clr_i    synchronous clear of overrun_o (a new overrun wins)
//
//   Handshake: sample_wr_o is a plain write strobe with no back-pressure.
//   A sample is offered for exactly the cycle after its frame boundary; if
//   fifo_full_i is high in that cycle the strobe is suppressed, the sample is
//   lost and overrun_o is set. The filter never stalls.
// -----------------------------------------------------------------------------
module audioadc_cic_decim
    import audioadc_cic_decim_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ds_i,
    input  logic        enable_i,
    input  logic [1:0]  osr_i,
    input  logic        fifo_full_i,
    output logic [15:0] sample_o,
    output logic        sample_wr_o,
    output logic        overrun_o,
    input  logic        ovr_clr_i
);

    localparam logic [ACC_W-1:0] STEP_UP = ACC_W'(1);
    localparam logic [ACC_W-1:0] STEP_DN = {ACC_W{1'b1}};

    logic [CTR_W-1:0]    dec_ctr;
    logic [ACC_W-1:0]    i1, i2, i3;
    logic [SETTLE_W-1:0] settle_ctr;
    osr_e                osr_q;
    osr_e                osr_in;
    logic                boundary;
    logic                osr_changed;
    logic                wr_q;
    logic                overrun_q;

    assign osr_in      = osr_e'(osr_i);
    assign boundary    = enable_i && (dec_ctr == '0);
    assign osr_changed = (osr_in != osr_q);

    // Counter, integrators, OSR latch and settling.
    // The frame that starts at a boundary is timed by the OSR latched at that
    // same boundary, while the comb scales by osr_q, i.e. the OSR that timed
    // the frame just ended. A change therefore never mixes frame lengths
    // within the samples that settling lets through.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dec_ctr    <= '0;
            i1         <= '0;
            i2         <= '0;
            i3         <= '0;
            settle_ctr <= SETTLE_RELOAD;
            osr_q      <= OSR32;
            wr_q       <= 1'b0;
        end else if (!enable_i) begin
            dec_ctr    <= '0;
            i1         <= '0;
            i2         <= '0;
            i3         <= '0;
            settle_ctr <= SETTLE_RELOAD;
            osr_q      <= OSR32;
            wr_q       <= 1'b0;
        end else begin
            dec_ctr <= boundary ? osr_reload(osr_in) : dec_ctr - CTR_W'(1);
            // Registered cascade: each stage adds the previous stage's old value.
            i1 <= i1 + (ds_i ? STEP_UP : STEP_DN);
            i2 <= i2 + i1;
            i3 <= i3 + i2;
            if (boundary) begin
                osr_q <= osr_in;
                if (osr_changed) begin
                    settle_ctr <= SETTLE_RELOAD;
                    wr_q       <= 1'b0;
                end else if (settle_ctr != '0) begin
                    settle_ctr <= settle_ctr - SETTLE_W'(1);
                    wr_q       <= 1'b0;
                end else begin
                    wr_q <= 1'b1;
                end
            end else begin
                wr_q <= 1'b0;
            end
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overrun_q <= 1'b0;
        end else if (wr_q && fifo_full_i) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign sample_wr_o = wr_q && !fifo_full_i;
    assign overrun_o   = overrun_q;

    audioadc_cic_comb u_comb (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clear  (!enable_i),
        .strobe (boundary),
        .osr    (osr_q),
        .integ  (i3),
        .sample (sample_o)
    );

endmodule

// File: tb/tb_audioadc_cic_decim.sv
module tb_audioadc_cic_decim;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ds = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  osr = 2'd0;
    logic        fifo_full = 1'b0;
    logic        ovr_clr = 1'b0;
    logic [15:0] sample;
    logic        sample_wr;
    logic        overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // scoreboard: expected samples and the cycle each strobe is due
    logic [15:0] exp_q[$];
    int          exp_t_q[$];

    // reference model state
    int          hist[$];       // +1/-1 inputs since the filter was last cleared
    int          bt[$];         // input counts at the last three boundaries
    int          next_bnd = 0;
    int          m_settle = 3;
    logic [1:0]  m_osrq = 2'd0;
    logic        pend = 1'b0, nxt_pend = 1'b0;
    logic [15:0] pend_val = 16'h0, nxt_pend_val = 16'h0;
    logic        exp_ovr = 1'b0, nxt_ovr = 1'b0;
    logic [15:0] exp_sample = 16'h8000, nxt_sample = 16'h8000;

    // spec-level constant expected on every strobe of a directed phase
    logic        const_chk = 1'b0;
    int          const_val = 0;
    int          const_tol = 0;

    logic [15:0] mon_e;
    int          mon_t;
    int          diff;

    audioadc_cic_decim dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .ds_i        (ds),
        .enable_i    (enable),
        .osr_i       (osr),
        .fifo_full_i (fifo_full),
        .sample_o    (sample),
        .sample_wr_o (sample_wr),
        .overrun_o   (overrun),
        .ovr_clr_i   (ovr_clr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Third integrator after n clocked inputs: every input x[j] carries the
    // weight C(n-1-j, 2) (three cascaded running sums, two cycles of delay).
    function automatic longint i3_at(input int n);
        longint s;
        s = 0;
        for (int j = 0; j < n; j++)
            s += longint'(hist[j]) * ((longint'(n - 1 - j) * longint'(n - 2 - j)) / 2);
        return s;
    endfunction

    task automatic model_clear();
        hist.delete();
        bt.delete();
        next_bnd = 0;
        m_settle = 3;
        m_osrq   = 2'd0;
    endtask

    task automatic model_boundary(input logic [1:0] osr_v);
        int          n, sh;
        longint      v, sv;
        logic [25:0] w;
        logic [15:0] sat, uv;
        n = hist.size();
        // third difference of the integrator across the last four boundaries
        v = i3_at(n);
        if (bt.size() >= 1) v -= 3 * i3_at(bt[bt.size() - 1]);
        if (bt.size() >= 2) v += 3 * i3_at(bt[bt.size() - 2]);
        if (bt.size() >= 3) v -= i3_at(bt[bt.size() - 3]);
        w  = v[25:0];
        sv = longint'($signed(w));
        sh = 3 * (int'(m_osrq) + 5) - 15;
        sv = sv >>> sh;
        if (sv > 32767) sv = 32767;
        else if (sv < -32768) sv = -32768;
        sat = sv[15:0];
        uv  = sat ^ 16'h8000;
        nxt_sample = uv;
        if (osr_v != m_osrq) begin
            m_settle = 3;
            nxt_pend = 1'b0;
        end else if (m_settle != 0) begin
            m_settle--;
            nxt_pend = 1'b0;
        end else begin
            nxt_pend     = 1'b1;
            nxt_pend_val = uv;
        end
        m_osrq   = osr_v;
        next_bnd = n + (32 << osr_v);
        bt.push_back(n);
        if (bt.size() > 3) void'(bt.pop_front());
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic ds_v, input logic en_v, input logic [1:0] osr_v,
                        input logic full_v, input logic clr_v);
        logic set_v;
        @(posedge clk);
        #1;
        exp_ovr    = nxt_ovr;
        exp_sample = nxt_sample;
        pend       = nxt_pend;
        pend_val   = nxt_pend_val;
        ds         = ds_v;
        enable     = en_v;
        osr        = osr_v;
        fifo_full  = full_v;
        ovr_clr    = clr_v;
        set_v      = 1'b0;
        if (pend) begin
            if (full_v) set_v = 1'b1;
            else begin
                exp_q.push_back(pend_val);
                exp_t_q.push_back(cyc);
            end
        end
        nxt_ovr  = set_v ? 1'b1 : (clr_v ? 1'b0 : exp_ovr);
        nxt_pend = 1'b0;
        if (en_v) begin
            if (hist.size() == next_bnd) model_boundary(osr_v);
            hist.push_back(ds_v ? 1 : -1);
        end else begin
            model_clear();
        end
    endtask

    task automatic pulse_reset(input int ncyc);
        @(posedge clk);
        #1;
        enable    = 1'b0;
        fifo_full = 1'b0;
        ovr_clr   = 1'b0;
        #2 rst_n  = 1'b0;
        model_clear();
        exp_ovr = 1'b0;  nxt_ovr = 1'b0;
        exp_sample = 16'h8000;  nxt_sample = 16'h8000;
        pend = 1'b0;  nxt_pend = 1'b0;
        repeat (ncyc) @(posedge clk);
        #7 rst_n = 1'b1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        total++;
        if (overrun !== exp_ovr) begin
            bad++;
            $display("FAIL overrun_state: got %b want %b (cycle %0d)", overrun, exp_ovr, cyc);
        end
        total++;
        if (sample !== exp_sample) begin
            bad++;
            $display("FAIL sample_reg: got %h want %h (cycle %0d)", sample, exp_sample, cyc);
        end
        if (sample_wr !== 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected: got %b want 0 (cycle %0d)", sample_wr, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                if (sample !== mon_e) begin
                    bad++;
                    $display("FAIL strobe_value: got %h want %h (cycle %0d)", sample, mon_e, cyc);
                end
                total++;
                if (mon_t != cyc) begin
                    bad++;
                    $display("FAIL strobe_time: got cycle %0d want cycle %0d", cyc, mon_t);
                end
                if (const_chk) begin
                    total++;
                    diff = int'(sample) - const_val;
                    if (diff < 0) diff = -diff;
                    if (diff > const_tol) begin
                        bad++;
                        $display("FAIL settled_level: got %h want %h +/- %0d", sample, const_val, const_tol);
                    end
                end
            end
        end
        if (exp_t_q.size() != 0 && exp_t_q[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL strobe_missing: got none want %h at cycle %0d", exp_q[0], exp_t_q[0]);
            void'(exp_q.pop_front());
            void'(exp_t_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] dac_acc;
    logic [16:0] dac_sum;
    logic        b, f, c, alt;
    int          p, seg_osr;

    initial begin
        pulse_reset(2);
        @(negedge clk);
        check_bit("reset_wr", sample_wr, 1'b0);
        check_bit("reset_ovr", overrun, 1'b0);
        total++;
        if (sample !== 16'h8000) begin
            bad++;
            $display("FAIL reset_sample: got %h want 8000", sample);
        end

        // +full scale at OSR32: saturates to FFFF
        const_chk = 1'b1; const_val = 16'hFFFF; const_tol = 0;
        repeat (400) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        const_chk = 1'b0;
        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // -full scale at OSR256: 0000
        const_chk = 1'b1; const_val = 16'h0000; const_tol = 0;
        repeat (1800) step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        const_chk = 1'b0;
        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // alternating 1,0 at OSR64: exact zero
        const_chk = 1'b1; const_val = 16'h8000; const_tol = 0;
        alt = 1'b1;
        repeat (700) begin
            step(alt, 1'b1, 2'd1, 1'b0, 1'b0);
            alt = ~alt;
        end
        const_chk = 1'b0;
        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // loopback from a first-order modulator at full volume, input C000, OSR128
        const_chk = 1'b1; const_val = 16'hC000; const_tol = 1;
        dac_acc = 16'h0;
        repeat (1200) begin
            dac_sum = {1'b0, dac_acc} + 17'h0C000;
            dac_acc = dac_sum[15:0];
            step(dac_sum[16], 1'b1, 2'd2, 1'b0, 1'b0);
        end
        const_chk = 1'b0;
        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // FIFO full across a boundary, then clear
        repeat (200) step(1'($urandom_range(0, 1)), 1'b1, 2'd0, 1'b0, 1'b0);
        repeat (40) step(1'($urandom_range(0, 1)), 1'b1, 2'd0, 1'b1, 1'b0);
        repeat (20) step(1'($urandom_range(0, 1)), 1'b1, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_bit("overrun_set_held", overrun, 1'b1);
        step(1'($urandom_range(0, 1)), 1'b1, 2'd0, 1'b0, 1'b1);
        step(1'($urandom_range(0, 1)), 1'b1, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_bit("overrun_cleared", overrun, 1'b0);
        repeat (150) step(1'($urandom_range(0, 1)), 1'b1, 2'd0, 1'b0, 1'b0);

        // OSR change mid-frame, then reset mid-frame
        repeat (300 + $urandom_range(0, 20)) step(1'($urandom_range(0, 1)), 1'b1, 2'd0, 1'b0, 1'b0);
        repeat (1300) step(1'($urandom_range(0, 1)), 1'b1, 2'd3, 1'b0, 1'b0);
        pulse_reset(1);
        @(negedge clk);
        check_bit("midreset_ovr", overrun, 1'b0);
        total++;
        if (sample !== 16'h8000) begin
            bad++;
            $display("FAIL midreset_sample: got %h want 8000", sample);
        end
        repeat (1300) step(1'($urandom_range(0, 1)), 1'b1, 2'd3, 1'b0, 1'b0);

        // randomized segments: density, OSR, FIFO full and clear pulses
        for (int s = 0; s < 5; s++) begin
            seg_osr = $urandom_range(0, 2);
            p = $urandom_range(0, 16);
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 2'(seg_osr), 1'b0, 1'b0);
            for (int k = 0; k < 500; k++) begin
                b = ($urandom_range(0, 15) < p);
                f = ($urandom_range(0, 11) == 0);
                c = ($urandom_range(0, 19) == 0);
                step(b, 1'b1, 2'(seg_osr), f, c);
            end
        end

        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expected: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
